// File: rtl/hivek_mem_pkg.sv
// Shared memory-subsystem definitions: default BRAM geometry and the
// loader state encoding, used by the BRAM and by the byte loader.
package hivek_mem_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } load_state_t;

endpackage

// File: rtl/bram_loader_if.sv
// Byte-stream handshake plus BRAM write port of the loader.
// master: the loader side; slave: the environment (byte source + BRAM).
interface bram_loader_if
    import hivek_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_wren,
        output mem_addr,
        output mem_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_wren,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler. Each accepted byte enters at the
// top of a shift register, so after four bytes the first one sits in
// bits [7:0]. word_next/last present the completed word combinationally
// in the same cycle as the fourth byte so the caller can register it.
module byte_packer
    import hivek_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word_next,
    output logic              last
);

    logic [1:0]        lane_q;
    logic [DATA_W-9:0] shift_q;

    assign word_next = {byte_data, shift_q};
    assign last      = take && (lane_q == 2'(BYTES_PER_WORD - 1));

    // Byte lane index; clearing it is what discards a partial word.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane_q <= '0;
        end else if (take) begin
            lane_q <= lane_q + 2'd1;
        end
    end

    // Shift register holding the bytes received so far for this word.
    always_ff @(posedge clock) begin
        if (take) begin
            shift_q <= word_next[DATA_W-1:8];
        end
    end

endmodule

// File: rtl/bram_loader.sv
// Streams bytes into BRAM words: collects four bytes little-endian, writes
// the word at the current address for one cycle, advances the address
// (wrapping) and repeats until word_count words are written, then pulses
// done. Steady-state throughput is one word per five cycles.
module bram_loader
    import hivek_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    bram_loader_if.master     bus
);

    load_state_t       state_q;
    load_state_t       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              accept;
    logic              take;
    logic              byte_ready_c;
    logic              mem_wren_c;
    logic              word_last;
    logic [DATA_W-1:0] word_next;

    assign accept = (state_q == ST_IDLE) && start;
    assign take   = bus.byte_valid && byte_ready_c;

    assign bus.byte_ready = byte_ready_c;
    assign bus.mem_wren   = mem_wren_c;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign words_written  = words_q;

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .take      (take),
        .byte_data (bus.byte_data),
        .word_next (word_next),
        .last      (word_last)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; all status outputs are pure functions of state.
    always_comb begin
        state_d      = state_q;
        byte_ready_c = 1'b0;
        mem_wren_c   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                byte_ready_c = 1'b1;
                busy         = 1'b1;
                if (word_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_wren_c = 1'b1;
                busy       = 1'b1;
                // remain_q still counts the word being written now.
                state_d = (remain_q == (ADDR_W + 1)'(1)) ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address / count bookkeeping and the registered BRAM write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            words_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q   <= base_addr;
                remain_q <= word_count;
                words_q  <= '0;
            end
            // Capture the word on its fourth byte so it is presented
            // exactly during WRITE and then held until the next word.
            if (state_q == ST_COLLECT && word_last) begin
                mem_addr_q <= addr_q;
                mem_data_q <= word_next;
            end
            if (state_q == ST_WRITE) begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
                words_q  <= words_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width (256-word BRAM).
REQ-002 SHALL have parameter DATA_W, default 32, BRAM word width; fixed at 4 bytes.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin a load; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W, first BRAM word address; latched on accepted start.
REQ-007 SHALL have port word_count, input, ADDR_W+1, words to load (0..256); latched on accepted start.
REQ-008 SHALL have port byte_valid, input, 1, upstream byte present.
REQ-009 SHALL have port byte_data, input, 8, upstream byte.
REQ-010 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-011 SHALL have port mem_wren, output, 1, BRAM write enable.
REQ-012 SHALL have port mem_addr, output, ADDR_W, BRAM word address.
REQ-013 SHALL have port mem_data, output, DATA_W, BRAM write data.
REQ-014 SHALL have port busy, output, 1, high in COLLECT and WRITE.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port words_written, output, ADDR_W+1, words written since last accepted start.

Function
REQ-017 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE: start=1 SHALL latch base_addr/word_count, clear words_written, go COLLECT; if word_count=0, go DONE instead.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 A byte SHALL transfer only when byte_valid & byte_ready are both high in the same cycle; byte_ready SHALL be 1 only in COLLECT.
REQ-021 Byte assembly SHALL be little-endian: transfer k (0..3) fills mem_data bits [8k+7:8k].
REQ-022 The cycle after the 4th transfer SHALL be WRITE: mem_wren=1 for exactly one cycle, mem_addr=current address, mem_data=assembled word.
REQ-023 After WRITE: address +1 modulo 2^ADDR_W (255 wraps to 0), words_written +1, remaining -1; remaining=0 -> DONE, else COLLECT.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 byte_valid gaps SHALL only stall assembly; no byte lost or duplicated.
REQ-026 mem_wren SHALL be 0 in every state except WRITE.
REQ-027 mem_addr and mem_data SHALL hold their last values outside WRITE.
REQ-028 Throughput SHALL be one word per 5 cycles with byte_valid held high.

Reset
REQ-029 On reset: state IDLE; byte_ready, mem_wren, busy, done = 0; mem_addr, mem_data, words_written = 0.
REQ-030 Reset mid-load SHALL abort immediately; a partially assembled word SHALL be discarded and never written.
REQ-031 Reset SHALL take priority over start and byte transfers in the same cycle.

Structure
REQ-032 State encodings and ADDR_W/DATA_W defaults SHALL live in shared package hivek_mem_pkg, reused by bram and this block.
REQ-033 Byte-to-word assembly (byte lane index, shift register) SHALL be a sub-module byte_packer; FSM, address and count logic stay in bram_loader.

Verification
REQ-034 Load: base 0x10, count 2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x10, 0x88776655@0x11; done pulse; words_written=2.
REQ-035 Wrap: base 0xFF, count 2 -> writes at 0xFF then 0x00.
REQ-036 Zero count: start with count 0 -> done one cycle after start; no mem_wren; byte_ready stays 0.
REQ-037 Backpressure: byte_valid toggled every other cycle -> identical written words; mem_wren pulses exactly once per word.
REQ-038 Reset after 2 bytes of word 1 -> no write; all outputs at reset values next cycle; fresh load then works.
REQ-039 Full: count 256 from base 0 with continuous bytes -> 256 writes, done 1280 +/- 2 cycles after start; start pulses mid-load ignored.
